// File: rtl/sobel_uart_pkg.sv
// rtl/sobel_uart_pkg.sv - shared constants, FSM states and header byte helper for the frame UART sender
package sobel_uart_pkg;

   localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
   localparam logic [7:0] SYNC_BYTE1 = 8'h5A;
   localparam int         HDR_LEN    = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FETCH,
      ST_LOAD,
      ST_PAY,
      ST_CSUM,
      ST_DONE,
      ST_WAIT_CLR
   } state_t;

   // Header byte at position idx: two sync bytes, frame id MSB first, length MSB first.
   function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                           input logic [31:0] id,
                                           input logic [15:0] len);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE0;
         3'd1:    b = SYNC_BYTE1;
         3'd2:    b = id[31:24];
         3'd3:    b = id[23:16];
         3'd4:    b = id[15:8];
         3'd5:    b = id[7:0];
         3'd6:    b = len[15:8];
         default: b = len[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sobel_frame_uart_sender_if.sv
// rtl/sobel_frame_uart_sender_if.sv - BRAM read port and UART byte stream between sender and its neighbours
interface sobel_frame_uart_sender_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [7:0]            rd_data;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (
      output rd_addr,
      output tx_data,
      output tx_valid,
      input  rd_data,
      input  tx_ready
   );

   modport slave (
      input  rd_addr,
      input  tx_data,
      input  tx_valid,
      output rd_data,
      output tx_ready
   );
endinterface

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop level synchronizer for a single asynchronous bit
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   // Shift the async level through the flop chain; reset clears every stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/sobel_frame_uart_sender.sv
// rtl/sobel_frame_uart_sender.sv - sends a captured 1-bpp frame as a framed UART packet and releases the buffer
module sobel_frame_uart_sender
   import sobel_uart_pkg::*;
#(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int PAYLOAD_LEN = (WIDTH * HEIGHT) / 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk_uart,
   input  logic                      rst_n,
   input  logic                      frame_ready_vga,
   input  logic [31:0]               frame_id_vga,
   sobel_frame_uart_sender_if.master bus,
   output logic                      consume_toggle_uart,
   output logic                      busy,
   output logic [15:0]               frames_sent
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PAYLOAD_LEN - 1);
   localparam logic [15:0]           LEN16     = 16'(PAYLOAD_LEN);
   localparam logic [2:0]            LAST_HDR  = 3'(HDR_LEN - 1);

   state_t                state_q;
   logic [2:0]            idx_q;
   logic [31:0]           id_q;
   logic [7:0]            csum_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [7:0]            tx_data_q;
   logic                  tx_valid_q;
   logic                  toggle_q;
   logic [15:0]           frames_q;
   logic                  ready_s;
   logic                  accept;

   // The frame id is not synchronized: it is only sampled once the synchronized ready is seen,
   // and the capture side holds it stable for as long as FULL is asserted.
   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ready (
      .clk   (clk_uart),
      .rst_n (rst_n),
      .d_i   (frame_ready_vga),
      .q_o   (ready_s)
   );

   assign accept = tx_valid_q && bus.tx_ready;

   // Packet sequencer: header, fetch/load/present per payload byte, checksum, release, wait for clear.
   always_ff @(posedge clk_uart) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         id_q       <= '0;
         csum_q     <= '0;
         rd_addr_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         toggle_q   <= 1'b0;
         frames_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ready_s) begin
                  id_q       <= frame_id_vga;
                  idx_q      <= '0;
                  csum_q     <= '0;
                  tx_data_q  <= SYNC_BYTE0;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  if (idx_q == LAST_HDR) begin
                     tx_valid_q <= 1'b0;
                     rd_addr_q  <= '0;
                     state_q    <= ST_FETCH;
                  end else begin
                     idx_q     <= idx_q + 3'd1;
                     tx_data_q <= hdr_byte(idx_q + 3'd1, id_q, LEN16);
                  end
               end
            end
            ST_FETCH: begin
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               tx_data_q  <= bus.rd_data;
               tx_valid_q <= 1'b1;
               csum_q     <= csum_q ^ bus.rd_data;
               state_q    <= ST_PAY;
            end
            ST_PAY: begin
               if (accept) begin
                  if (rd_addr_q == LAST_ADDR) begin
                     tx_data_q <= csum_q;
                     state_q   <= ST_CSUM;
                  end else begin
                     tx_valid_q <= 1'b0;
                     rd_addr_q  <= rd_addr_q + 1'b1;
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               toggle_q <= ~toggle_q;
               frames_q <= frames_q + 16'd1;
               state_q  <= ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
               if (!ready_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rd_addr          = rd_addr_q;
   assign bus.tx_data          = tx_data_q;
   assign bus.tx_valid         = tx_valid_q;
   assign consume_toggle_uart  = toggle_q;
   assign frames_sent          = frames_q;
   assign busy                 = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sobel_frame_uart_sender.sv
// tb/tb_sobel_frame_uart_sender.sv - directed self-checking bench for the frame UART sender
module tb_sobel_frame_uart_sender;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_ready_vga;
   logic [31:0] frame_id_vga;
   logic        consume_toggle_uart;
   logic        busy;
   logic [15:0] frames_sent;

   sobel_frame_uart_sender_if #(.ADDR_WIDTH(16)) bus ();

   sobel_frame_uart_sender #(
      .WIDTH       (16),
      .HEIGHT      (2),
      .PAYLOAD_LEN (4),
      .ADDR_WIDTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk_uart            (clk),
      .rst_n               (rst_n),
      .frame_ready_vga     (frame_ready_vga),
      .frame_id_vga        (frame_id_vga),
      .bus                 (bus),
      .consume_toggle_uart (consume_toggle_uart),
      .busy                (busy),
      .frames_sent         (frames_sent)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [4];
   int         rdy_mode = 0;

   // tx_ready: 0 = always ready, 1 = random 30% ready, other = held low
   always @(negedge clk) begin
      if (rdy_mode == 0)      bus.tx_ready = 1'b1;
      else if (rdy_mode == 1) bus.tx_ready = ($urandom_range(0, 99) < 30);
      else                    bus.tx_ready = 1'b0;
   end

   // BRAM read port with one edge of latency
   always @(posedge clk) bus.rd_data <= ram[bus.rd_addr[1:0]];

   logic [7:0]  got_q [$];
   int          acc_q [$];
   int          cyc       = 0;
   int          tog_cyc   = 0;
   int          stab_err  = 0;
   logic        cons_prev = 1'b0;
   logic        hold_prev = 1'b0;
   logic [7:0]  data_prev = 8'h00;
   logic [15:0] max_addr  = 16'h0000;

   // Monitor: record accepted bytes and their edge, stall stability, toggle edge, peak address
   always @(posedge clk) begin
      cyc++;
      if (rst_n !== 1'b1) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && !(bus.tx_valid === 1'b1 && bus.tx_data === data_prev)) stab_err++;
         if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            got_q.push_back(bus.tx_data);
            acc_q.push_back(cyc);
         end
         hold_prev = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
         data_prev = bus.tx_data;
      end
      if (consume_toggle_uart !== cons_prev) begin
         tog_cyc   = cyc;
         cons_prev = consume_toggle_uart;
      end
      if (bus.rd_addr > max_addr) max_addr = bus.rd_addr;
   end

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic wait_bytes(input int n, input int limit);
      for (int i = 0; i < limit && got_q.size() < n; i++) @(negedge clk);
      check("byte_count_reached", 32'(got_q.size() >= n), 32'd1);
   endtask

   task automatic check_pkt(input string tag, input int base, input logic [31:0] id,
                            input logic [7:0] csum);
      logic [7:0] exp [13];
      exp[0] = 8'hA5;        exp[1] = 8'h5A;
      exp[2] = id[31:24];    exp[3] = id[23:16];
      exp[4] = id[15:8];     exp[5] = id[7:0];
      exp[6] = 8'h00;        exp[7] = 8'h04;
      for (int k = 0; k < 4; k++) exp[8 + k] = ram[k];
      exp[12] = csum;
      for (int i = 0; i < 13; i++)
         check($sformatf("%s_b%0d", tag, i), 32'(got_q[base + i]), 32'(exp[i]));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int base;
      int n;
      rst_n           = 1'b0;
      frame_ready_vga = 1'b0;
      frame_id_vga    = 32'h0;
      ram[0] = 8'h01; ram[1] = 8'h80; ram[2] = 8'hFF; ram[3] = 8'h3C;
      repeat (3) @(negedge clk);

      check("rst_rd_addr",  32'(bus.rd_addr), 32'h0);
      check("rst_tx_data",  32'(bus.tx_data), 32'h0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("rst_toggle",   32'(consume_toggle_uart), 32'h0);
      check("rst_busy",     32'(busy), 32'h0);
      check("rst_frames",   32'(frames_sent), 32'h0);

      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_ready_busy", 32'(busy), 32'h0);

      // Packet 1: id 7, always ready
      base            = got_q.size();
      frame_id_vga    = 32'h0000_0007;
      frame_ready_vga = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n++;
         if (bus.tx_valid === 1'b1) break;
      end
      check("ready_latency", 32'(n), 32'd3);
      check("first_byte",    32'(bus.tx_data), 32'hA5);
      wait_bytes(base + 13, 200);
      check_pkt("pkt1", base, 32'h0000_0007, 8'h42);
      check("pkt1_span", 32'(acc_q[base + 12] - acc_q[base]), 32'd20);
      repeat (5) @(negedge clk);
      check("pkt1_toggle_delay", 32'(tog_cyc - acc_q[base + 12]), 32'd2);
      check("pkt1_toggle", 32'(consume_toggle_uart), 32'h1);
      check("pkt1_frames", 32'(frames_sent), 32'h1);

      // Stale FULL level must not resend
      repeat (50) @(negedge clk);
      check("stale_no_resend", 32'(got_q.size()), 32'(base + 13));
      check("stale_busy",      32'(busy), 32'h1);
      frame_ready_vga = 1'b0;
      repeat (4) @(negedge clk);
      check("clear_to_idle", 32'(busy), 32'h0);

      // Packet 2: new id under random backpressure
      base            = got_q.size();
      frame_id_vga    = 32'hDEAD_BEEF;
      rdy_mode        = 1;
      frame_ready_vga = 1'b1;
      wait_bytes(base + 13, 3000);
      check_pkt("pkt2", base, 32'hDEAD_BEEF, 8'h42);
      check("pkt2_stall_stable", 32'(stab_err), 32'h0);
      rdy_mode = 0;
      repeat (5) @(negedge clk);
      check("pkt2_toggle", 32'(consume_toggle_uart), 32'h0);
      check("pkt2_frames", 32'(frames_sent), 32'h2);

      // Packet 3: reset during payload byte 2, then full resend
      frame_ready_vga = 1'b0;
      repeat (4) @(negedge clk);
      base            = got_q.size();
      frame_id_vga    = 32'h0000_0055;
      frame_ready_vga = 1'b1;
      wait_bytes(base + 10, 200);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_rd_addr",  32'(bus.rd_addr), 32'h0);
      check("mid_rst_tx_data",  32'(bus.tx_data), 32'h0);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("mid_rst_busy",     32'(busy), 32'h0);
      check("mid_rst_toggle",   32'(consume_toggle_uart), 32'h0);
      check("mid_rst_frames",   32'(frames_sent), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_no_extra", 32'(got_q.size()), 32'(base + 10));
      base = got_q.size();
      wait_bytes(base + 13, 200);
      check_pkt("pkt3", base, 32'h0000_0055, 8'h42);
      repeat (5) @(negedge clk);
      check("pkt3_toggle", 32'(consume_toggle_uart), 32'h1);
      check("pkt3_frames", 32'(frames_sent), 32'h1);

      // Packet 4: one-cycle ready glitch during the payload is ignored
      frame_ready_vga = 1'b0;
      repeat (4) @(negedge clk);
      ram[0] = 8'h10; ram[1] = 8'h20; ram[2] = 8'h30; ram[3] = 8'h40;
      base            = got_q.size();
      frame_id_vga    = 32'h0000_A0A0;
      frame_ready_vga = 1'b1;
      wait_bytes(base + 9, 200);
      frame_ready_vga = 1'b0;
      @(negedge clk);
      frame_ready_vga = 1'b1;
      wait_bytes(base + 13, 200);
      check_pkt("pkt4", base, 32'h0000_A0A0, 8'h40);
      repeat (5) @(negedge clk);
      check("pkt4_toggle", 32'(consume_toggle_uart), 32'h0);
      check("pkt4_frames", 32'(frames_sent), 32'h2);
      check("pkt4_wait_clr_busy", 32'(busy), 32'h1);

      check("rd_addr_max", 32'(max_addr), 32'd3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sobel_frame_uart_sender.md
# sobel_frame_uart_sender

UART-domain reader for the 1-bpp Sobel frame buffer. When the capture side reports a full frame, this block sends a framed packet to the byte-wide UART transmitter: header, frame ID, length, the packed payload read from the BRAM read port, and a checksum. It then toggles the consume line so the capture side returns to EMPTY. It sits between the frame capture BRAM (`clk_uart` read port) and `uart_tx`.

## Interface
Parameters:
- `WIDTH`, default 640: frame width in pixels.
- `HEIGHT`, default 480: frame height in lines.
- `PAYLOAD_LEN`, default (WIDTH*HEIGHT)/8 = 38400: payload byte count.
- `ADDR_WIDTH`, default 16: BRAM address width.
- `SYNC_STAGES`, default 2: flop count of the `frame_ready_vga` synchronizer (≥2).

Ports:
- `clk_uart` in 1: the block's single clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `frame_ready_vga` in 1: FULL level from the VGA domain. Asynchronous; synchronized internally.
- `frame_id_vga` in 32: frame counter from the VGA domain. Stable while FULL is asserted.
- `rd_addr` out ADDR_WIDTH: BRAM read address. Registered.
- `rd_data` in 8: BRAM read data. Valid one `clk_uart` edge after `rd_addr`.
- `consume_toggle_uart` out 1: inverts once per completed packet.
- `tx_data` out 8: byte offered to `uart_tx`.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: `uart_tx` can accept a byte.
- `busy` out 1: high in every state except IDLE.
- `frames_sent` out 16: count of completed packets. Wraps at 0xFFFF→0.

## Operation
Packet byte order, 38409 bytes total:
- 0xA5, 0x5A.
- `frame_id` [31:24], [23:16], [15:8], [7:0].
- PAYLOAD_LEN [15:8], [7:0].
- Payload: `ram[0]` … `ram[PAYLOAD_LEN-1]`.
- CSUM: XOR of all payload bytes only.

Transfer rule:
- A byte transfers on a rising edge where `tx_valid` && `tx_ready`.
- While `tx_valid`=1, `tx_data` is held stable.
- `tx_valid` never drops before the byte is accepted.

FSM:
- IDLE: wait for synchronized ready = 1. On that edge, latch `frame_id_vga` into `id_q`, clear the byte index and checksum, go to HDR.
- HDR: present the 8 header/ID/length bytes in sequence. After the last header byte is accepted, drive `rd_addr`=0 and go to FETCH.
- FETCH: one-cycle wait for the BRAM read. Then go to LOAD.
- LOAD: register `rd_data` into `tx_data`, assert `tx_valid`, XOR it into the checksum. Go to PAY.
- PAY: when the byte is accepted:
  - if `rd_addr` == PAYLOAD_LEN-1, go to CSUM;
  - otherwise `rd_addr`++ and go to FETCH.
- CSUM: present the checksum byte. When accepted, go to DONE.
- DONE: for one cycle, invert `consume_toggle_uart` and increment `frames_sent`. Go to WAIT_CLR.
- WAIT_CLR: stay until synchronized ready = 0, then go to IDLE. This prevents re-sending the same frame on a stale FULL level.

Width and value rules:
- `rd_addr` never exceeds PAYLOAD_LEN-1.
- Header length field = PAYLOAD_LEN[15:0].

## Timing
- Reset values: `rd_addr`=0, `tx_data`=0x00, `tx_valid`=0, `consume_toggle_uart`=0, `busy`=0, `frames_sent`=0, FSM=IDLE, synchronizer flops=0.
- Ready latency: first `tx_valid` (byte 0xA5) occurs SYNC_STAGES+1 edges after `frame_ready_vga` rises.
- Header bytes: back-to-back. The next byte is presented in the cycle after acceptance.
- Payload byte N+1: acceptance at edge E → `rd_addr`++ at E, `rd_data` at E+1, `tx_valid`=1 after E+2. This gives exactly 2 idle `tx_valid` cycles per payload byte.
- Checksum byte: presented the cycle after the last payload byte is accepted.
- `consume_toggle_uart`: inverts one edge after the checksum is accepted.
- Ready dropping mid-packet: ignored. The packet always completes, because the writer holds FULL until consumed.
- Reset mid-packet: synchronous abort to reset values. The capture side stays FULL, so the frame is resent in full after reset.
- `tx_ready` held 0: the block stalls indefinitely with data held, with no timeout.

## Structure
- Shared package `sobel_uart_pkg`:
  - sync bytes 0xA5/0x5A;
  - header length = 8;
  - FSM state enum (IDLE, HDR, FETCH, LOAD, PAY, CSUM, DONE, WAIT_CLR).
- Sub-module `sync_bit` (SYNC_STAGES flops, level synchronizer) for `frame_ready_vga`. It is reused by other CDC level inputs.
- `frame_id_vga` gets no synchronizer. It is sampled only after ready is synchronized, under the stability guarantee.

## Test plan
- Small frame (WIDTH=16, HEIGHT=2, PAYLOAD_LEN=4), BRAM model {0x01,0x80,0xFF,0x3C}, id=7, `tx_ready`=1 → bytes A5 5A 00 00 00 07 00 04 01 80 FF 3C 42. Then `consume_toggle_uart` 0→1 and `frames_sent`=1.
- Random `tx_ready` backpressure, 30% duty → identical byte stream. `tx_data` never changes while `tx_valid`=1 && !`tx_ready`.
- Ready stays 1 for 50 cycles after the toggle → no second packet. Ready 0 then 1 → second packet with the new id, `consume_toggle_uart` back to 0.
- Assert `rst_n`=0 during payload byte 2 → all outputs at reset values next edge. With ready still 1, the full packet restarts from 0xA5.
- Default parameters, zero payload → 38409 bytes, length field 0x96 0x00, CSUM 0x00, last `rd_addr`=38399.
- Pulse ready low for 1 cycle during the payload → packet unaffected and completes normally.
